// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns four debounced direction buttons into the snake heading.
// Press edges are filtered (no reversal, no repeat), queued in a small
// circular FIFO, and applied one per game_tick.
// Optional macro SNAKE_DIR_TURN_COUNT_EN adds a saturating 16-bit turn counter.
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        en,
    input  logic        game_tick,
    output logic [1:0]  dir,
    output logic        dir_changed,
    output logic        drop,
    output logic        q_full
`ifdef SNAKE_DIR_TURN_COUNT_EN
    ,
    output logic [15:0] turn_count
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [1:0] D_RIGHT = 2'b00;
    localparam logic [1:0] D_UP    = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_DOWN  = 2'b11;

    localparam logic [1:0] LAST_IDX = 2'(QDEPTH - 1);
    localparam logic [2:0] DEPTH    = 3'(QDEPTH);

    // Circular pointer advance, wrapping at the configured depth.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    logic [0:0]      state_q, state_d;
    logic [3:0]      prev_q, prev_d;
    logic [1:0]      dir_q, dir_d;
    logic            dir_changed_q, dir_changed_d;
    logic            drop_q, drop_d;
    logic            q_full_q, q_full_d;
    logic [3:0][1:0] mem_q, mem_d;
    logic [1:0]      head_q, head_d;
    logic [1:0]      tail_q, tail_d;
    logic [2:0]      count_q, count_d;
    logic [15:0]     tc_q, tc_d;

    logic [3:0] btns;
    logic [3:0] press;
    logic       cand_vld;
    logic [1:0] cand_dir;
    logic [1:0] ref_dir;
    logic [1:0] last_idx;
    logic       pop;
    logic       push;

    assign btns  = {btn_up, btn_down, btn_left, btn_right};
    assign press = btns & ~prev_q;

    // Fixed-priority pick of one candidate per cycle: UP > DOWN > LEFT > RIGHT.
    always_comb begin
        cand_vld = 1'b1;
        cand_dir = D_RIGHT;
        if (press[3])      cand_dir = D_UP;
        else if (press[2]) cand_dir = D_DOWN;
        else if (press[1]) cand_dir = D_LEFT;
        else if (press[0]) cand_dir = D_RIGHT;
        else               cand_vld = 1'b0;
    end

    // Legality is judged against the newest queued turn, or the live heading
    // when nothing is pending; the tail counts even if it is popped this cycle.
    always_comb begin
        last_idx = (tail_q == 2'd0) ? LAST_IDX : tail_q - 2'd1;
        ref_dir  = (count_q != 3'd0) ? mem_q[last_idx] : dir_q;
        pop      = (state_q == RUN) && en && game_tick && (count_q != 3'd0);
        push     = (state_q == RUN) && en && cand_vld &&
                   (cand_dir != ref_dir) && (cand_dir != (ref_dir ^ 2'b10)) &&
                   ((count_q < DEPTH) || pop);
    end

    // Next-state logic for the run/idle control, queue and heading.
    always_comb begin
        state_d       = state_q;
        prev_d        = btns;
        dir_d         = dir_q;
        dir_changed_d = 1'b0;
        drop_d        = 1'b0;
        mem_d         = mem_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        tc_d          = tc_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d       = RUN;
                    dir_d         = INIT_DIR;
                    dir_changed_d = (dir_q != INIT_DIR);
                    head_d        = 2'd0;
                    tail_d        = 2'd0;
                    count_d       = 3'd0;
                    tc_d          = 16'd0;
                end
            end
            default: begin
                if (!en) begin
                    state_d = IDLE;
                    head_d  = 2'd0;
                    tail_d  = 2'd0;
                    count_d = 3'd0;
                end else begin
                    if (pop) begin
                        dir_d         = mem_q[head_q];
                        dir_changed_d = (mem_q[head_q] != dir_q);
                        head_d        = ptr_inc(head_q);
                        if ((mem_q[head_q] != dir_q) && (tc_q != 16'hFFFF))
                            tc_d = tc_q + 16'd1;
                    end
                    if (push) begin
                        mem_d[tail_q] = cand_dir;
                        tail_d        = ptr_inc(tail_q);
                    end else if (cand_vld) begin
                        drop_d = 1'b1;
                    end
                    count_d = count_q + {2'b00, push} - {2'b00, pop};
                end
            end
        endcase
        q_full_d = (count_d == DEPTH);
    end

    // Register all state; async reset returns to a clean, idle game.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            prev_q        <= 4'b1111;
            dir_q         <= INIT_DIR;
            dir_changed_q <= 1'b0;
            drop_q        <= 1'b0;
            q_full_q      <= 1'b0;
            mem_q         <= '0;
            head_q        <= 2'd0;
            tail_q        <= 2'd0;
            count_q       <= 3'd0;
            tc_q          <= 16'd0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            dir_q         <= dir_d;
            dir_changed_q <= dir_changed_d;
            drop_q        <= drop_d;
            q_full_q      <= q_full_d;
            mem_q         <= mem_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            tc_q          <= tc_d;
        end
    end

    assign dir         = dir_q;
    assign dir_changed = dir_changed_q;
    assign drop        = drop_q;
    assign q_full      = q_full_q;

`ifdef SNAKE_DIR_TURN_COUNT_EN
    assign turn_count = tc_q;
`else
    logic unused_tc;
    assign unused_tc = ^tc_q;
`endif

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl (QDEPTH=2, INIT_DIR=RIGHT).
module tb_snake_dir_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btns;  // {up, down, left, right}
    logic       en;
    logic       game_tick;
    logic [1:0] dir;
    logic       dir_changed;
    logic       drop;
    logic       q_full;
`ifdef SNAKE_DIR_TURN_COUNT_EN
    logic [15:0] turn_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] B_UP    = 4'b1000;
    localparam logic [3:0] B_DOWN  = 4'b0100;
    localparam logic [3:0] B_LEFT  = 4'b0010;
    localparam logic [3:0] B_RIGHT = 4'b0001;

    snake_dir_ctrl #(.QDEPTH(2), .INIT_DIR(2'b00)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btns[3]),
        .btn_down    (btns[2]),
        .btn_left    (btns[1]),
        .btn_right   (btns[0]),
        .en          (en),
        .game_tick   (game_tick),
        .dir         (dir),
        .dir_changed (dir_changed),
        .drop        (drop),
        .q_full      (q_full)
`ifdef SNAKE_DIR_TURN_COUNT_EN
        ,
        .turn_count  (turn_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press for one cycle, then release for one cycle.
    task automatic tap(input logic [3:0] b);
        btns = b;
        step();
        btns = 4'b0000;
        step();
    endtask

    task automatic tick();
        game_tick = 1'b1;
        step();
        game_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; btns = 4'b0000; en = 1'b0; game_tick = 1'b0;
        step(); step();
        check("rst_dir", dir, 0);
        check("rst_dchg", dir_changed, 0);
        check("rst_drop", drop, 0);
        check("rst_qfull", q_full, 0);

        // Leave reset and start the game; dir already INIT_DIR so no pulse.
        reset = 1'b0; en = 1'b1;
        step();
        check("start_dchg", dir_changed, 0);

        // UP held 5 cycles, then one tick.
        btns = B_UP;
        step();
        check("up_drop0", drop, 0);
        check("up_qfull", q_full, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("up_hold_drop", drop, 0);
        end
        btns = 4'b0000;
        tick();
        check("up_dir", dir, 1);
        check("up_dchg1", dir_changed, 1);
        step();
        check("up_dchg0", dir_changed, 0);
        check("up_dir_hold", dir, 1);

        // Back to RIGHT, then LEFT is a reversal.
        tap(B_RIGHT);
        tick();
        check("right_dir", dir, 0);
        btns = B_LEFT;
        step();
        check("rev_drop1", drop, 1);
        btns = 4'b0000;
        step();
        check("rev_drop0", drop, 0);
        tick();
        check("rev_dir", dir, 0);
        check("rev_dchg", dir_changed, 0);

        // Queue UP then LEFT from RIGHT: queue full.
        tap(B_UP);
        tap(B_LEFT);
        check("qf_full", q_full, 1);
        btns = B_DOWN;
        step();
        check("qf_drop", drop, 1);
        btns = 4'b0000;
        step();
        // DOWN together with a tick: UP pops, DOWN pushes behind LEFT.
        btns = B_DOWN; game_tick = 1'b1;
        step();
        btns = 4'b0000; game_tick = 1'b0;
        check("pp_dir", dir, 1);
        check("pp_dchg", dir_changed, 1);
        check("pp_drop", drop, 0);
        check("pp_qfull", q_full, 1);
        tick();
        check("pp_dir2", dir, 2);
        check("pp_qfull2", q_full, 0);
        tick();
        check("pp_dir3", dir, 3);
        tick();
        check("empty_dir", dir, 3);
        check("empty_dchg", dir_changed, 0);

        // Simultaneous UP+LEFT from RIGHT: only UP wins, no drop.
        tap(B_RIGHT);
        tick();
        check("sim_pre", dir, 0);
        btns = B_UP | B_LEFT;
        step();
        check("sim_drop", drop, 0);
        btns = 4'b0000;
        step();
        tick();
        check("sim_dir", dir, 1);
        tick();
        check("sim_dir2", dir, 1);
`ifdef SNAKE_DIR_TURN_COUNT_EN
        check("tc_run", turn_count, 7);
`endif

        // Pending turns, pause, resume: reset to INIT_DIR with empty queue.
        tap(B_LEFT);
        tap(B_DOWN);
        check("pause_qfull_pre", q_full, 1);
        en = 1'b0;
        step();
        check("pause_dir", dir, 1);
        check("pause_qfull", q_full, 0);
        en = 1'b1;
        step();
        check("resume_dir", dir, 0);
        check("resume_dchg", dir_changed, 1);
        check("resume_qfull", q_full, 0);
`ifdef SNAKE_DIR_TURN_COUNT_EN
        check("tc_clear", turn_count, 0);
`endif
        tick();
        check("resume_tick1", dir, 0);
        tick();
        check("resume_tick2", dir, 0);
        check("resume_dchg2", dir_changed, 0);

        // Mid-game reset drops queued turns immediately.
        tap(B_UP);
        tick();
        check("mr_pre", dir, 1);
        tap(B_LEFT);
        #2 reset = 1'b1;
        #1;
        check("mr_dir", dir, 0);
        check("mr_qfull", q_full, 0);
        step();
        reset = 1'b0;
        step();
        tick();
        check("mr_tick_dir", dir, 0);
        check("mr_tick_dchg", dir_changed, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Downstream of the per-button debouncers. Consumes four debounced direction levels and turns them into the snake's current heading.
- Detects press edges, rejects illegal turns (180° reversal, same direction), and buffers up to QDEPTH pending turns in a small FIFO.
- Applies one queued turn per game_tick, so fast double-taps between moves are not lost.
- The heading output feeds the snake movement/position engine.

Parameters:
- QDEPTH, 2: turn-queue depth; legal values 1..4.
- INIT_DIR, 2'b00: heading loaded at reset and at game start.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_up  in  1  debounced level, 1 = pressed
- btn_down  in  1  debounced level
- btn_left  in  1  debounced level
- btn_right  in  1  debounced level
- en  in  1  game running; 0 = paused/over
- game_tick  in  1  one-cycle pulse, once per snake move
- dir  out  2  current heading: 00 RIGHT, 01 UP, 10 LEFT, 11 DOWN
- dir_changed  out  1  one-cycle pulse, cycle after dir changes
- drop  out  1  one-cycle pulse, press rejected
- q_full  out  1  queue holds QDEPTH entries

Behaviour:
- Reset: async, active-high. On assertion:
  - dir=INIT_DIR; dir_changed=0; drop=0; q_full=0.
  - Queue empty; state=IDLE.
  - Button history registers=1111, so a button held through reset produces no press.
- Edge detect: press_x = btn_x & ~prev_x; prev_x registered every cycle in every state.
- Simultaneous presses in one cycle: priority UP > DOWN > LEFT > RIGHT. Only the winner is a candidate; losers are discarded silently (no drop pulse).
- Opposite heading: d ^ 2'b10.
- Reference heading ref = queue tail if the queue is non-empty, else dir.
- State IDLE:
  - Inputs and game_tick ignored; queue held empty; dir holds.
  - en=1 -> RUN. On that transition: dir loads INIT_DIR, queue cleared. dir_changed pulses only if dir actually changed.
- State RUN:
  - en=0 -> IDLE. Queue flushed on the same edge; dir holds.
  - Candidate accepted (pushed) iff: cand != ref, AND cand != ref^2'b10, AND (count<QDEPTH OR pop this cycle).
  - Candidate that fails any condition: drop=1 for the next cycle, no push.
  - Pop occurs when game_tick=1 and count>0. dir <= head on that edge; dir_changed=1 for the following cycle.
  - game_tick with an empty queue: dir holds, no pulse.
  - Push and pop in the same cycle: both performed; count unchanged.
  - With count==1, the push is compared against that entry (the tail), even though it is being popped.
  - No bypass: a candidate pushed into an empty queue on a tick cycle is applied at the next tick, not the current one.
- Latency: press edge to queue = 1 cycle; queue to dir = next game_tick edge.
- q_full is registered and equals (count==QDEPTH).
- en and game_tick both rising in the same cycle (IDLE->RUN): tick ignored.
- Queue is a circular buffer: head/tail pointers wrap modulo QDEPTH, plus an explicit count register; no pointer-equality ambiguity.
- Reset mid-game: everything returns to reset values immediately; pending turns are lost.

Optional Feature:
- Macro: SNAKE_DIR_TURN_COUNT_EN.
- Defined:
  - Adds output turn_count, 16 bits.
  - Increments on each pop that changes dir; saturates at 16'hFFFF.
  - Cleared by reset and on the IDLE->RUN transition.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, en=1, press btn_up for 5 cycles, one game_tick -> dir 00->01; dir_changed high exactly 1 cycle; drop never asserted.
- dir=RIGHT, press LEFT -> drop pulses 1 cycle; dir stays 00 after the next tick.
- dir=RIGHT, QDEPTH=2: press UP, release, press LEFT before any tick; then 2 ticks -> dir 01 then 10 (LEFT legal relative to queued UP).
- Queue full (UP, LEFT queued from RIGHT), press DOWN with no tick -> drop pulses. Repeat DOWN in the same cycle as a tick -> accepted; count stays 2.
- btn_up and btn_left rise in the same cycle from RIGHT -> only UP queued; after a tick dir=01; no drop.
- Mid-queue, drop en to 0, then raise en -> dir=INIT_DIR, queue empty; subsequent ticks leave dir unchanged. With the macro defined, turn_count reads 0.
